aes_block_gasket: RTL and testbench

Packs the 32-bit word stream from the AXI4 slave interface into 128-bit key and plaintext blocks for the AES encrypt core, and hands them over with a valid/ready handshake. Captures the core's 128-bit ciphertext and unpacks it into a 32-bit word stream for the slave's read path. Sits between the AXI4 slave register/burst logic and the AES core, with at most one block in flight.

---
 rtl/aes_block_gasket.sv | 139 +++++++++++++
 tb/tb_aes_block_gasket.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_block_gasket.sv
// Packs 32-bit slave words into 128-bit AES key/plaintext blocks, hands blocks
// to the core with valid/ready, and unpacks the ciphertext into a 32-bit stream.
module aes_block_gasket #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned BLOCK_WIDTH = 128
) (
   input  logic                   ACLK,
   input  logic                   ARESET,
   input  logic [DATA_WIDTH-1:0]  s_wdata,
   input  logic                   s_wkey,
   input  logic                   s_wvalid,
   output logic                   s_wready,
   output logic [BLOCK_WIDTH-1:0] key_out,
   output logic                   key_valid,
   output logic [BLOCK_WIDTH-1:0] blk_out,
   output logic                   blk_valid,
   input  logic                   blk_ready,
   input  logic [BLOCK_WIDTH-1:0] res_in,
   input  logic                   res_valid,
   output logic [DATA_WIDTH-1:0]  m_rdata,
   output logic                   m_rvalid,
   input  logic                   m_rready,
   output logic                   busy,
   output logic                   ovf_err
);

   localparam int unsigned WORDS = BLOCK_WIDTH / DATA_WIDTH;
   localparam int unsigned CW    = $clog2(WORDS);
   localparam int unsigned GW    = BLOCK_WIDTH - DATA_WIDTH;

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      HOLD     = 2'd1,
      WAIT_RES = 2'd2
   } state_t;

   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    mode;
   logic [GW-1:0]           grp;
   logic [GW-1:0]           rem;
   logic [CW-1:0]           rcnt;

   logic                    w_fire;
   logic                    r_fire;
   logic                    last_word;
   logic                    mode_cur;
   logic                    going_hold;
   logic                    res_ok;
   logic                    res_bad;
   logic                    last_take;
   logic                    rv_nx;
   logic                    hold_nx;
   logic                    fill_nx;
   logic [CW-1:0]           cnt_nx;
   logic [BLOCK_WIDTH-1:0]  full;

   // Handshake events and next-cycle views used by the registered status outputs
   assign w_fire     = s_wvalid && s_wready && (state == FILL);
   assign r_fire     = m_rvalid && m_rready;
   assign last_word  = (cnt == CW'(WORDS - 1));
   assign mode_cur   = (cnt == '0) ? s_wkey : mode;
   assign going_hold = w_fire && last_word && !mode_cur;
   assign res_ok     = res_valid && (state == WAIT_RES);
   assign res_bad    = res_valid && (state != WAIT_RES);
   assign last_take  = r_fire && (rcnt == CW'(WORDS - 1));
   assign rv_nx      = res_ok ? 1'b1 : (last_take ? 1'b0 : m_rvalid);
   assign hold_nx    = ((state == HOLD) && !(blk_valid && blk_ready)) || going_hold;
   assign fill_nx    = ((state == FILL) && !going_hold) || res_ok;
   assign cnt_nx     = w_fire ? cnt + CW'(1) : cnt;
   assign full       = {grp, s_wdata};

   // Input FSM, output unpacker and registered status flags
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= FILL;
         cnt       <= '0;
         mode      <= 1'b0;
         grp       <= '0;
         rem       <= '0;
         rcnt      <= '0;
         key_out   <= '0;
         key_valid <= 1'b0;
         blk_out   <= '0;
         blk_valid <= 1'b0;
         m_rdata   <= '0;
         m_rvalid  <= 1'b0;
         ovf_err   <= 1'b0;
         busy      <= 1'b0;
         s_wready  <= 1'b1;
      end else begin
         key_valid <= 1'b0;
         if (res_bad) ovf_err <= 1'b1;

         case (state)
            FILL: begin
               if (w_fire) begin
                  grp <= {grp[GW-DATA_WIDTH-1:0], s_wdata};
                  cnt <= cnt_nx;
                  if (cnt == '0) mode <= s_wkey;
                  if (last_word) begin
                     if (mode_cur) begin
                        key_out   <= full;
                        key_valid <= 1'b1;
                     end else begin
                        blk_out <= full;
                        state   <= HOLD;
                     end
                  end
               end
            end
            HOLD: begin
               if (blk_valid && blk_ready) state <= WAIT_RES;
            end
            WAIT_RES: begin
               if (res_valid) state <= FILL;
            end
            default: state <= FILL;
         endcase

         if (res_ok) begin
            m_rdata <= res_in[BLOCK_WIDTH-1 -: DATA_WIDTH];
            rem     <= res_in[GW-1:0];
            rcnt    <= '0;
         end else if (r_fire && !last_take) begin
            m_rdata <= rem[GW-1 -: DATA_WIDTH];
            rem     <= {rem[GW-DATA_WIDTH-1:0], DATA_WIDTH'(0)};
            rcnt    <= rcnt + CW'(1);
         end

         m_rvalid  <= rv_nx;
         // Block is only offered once the result buffer is guaranteed free
         blk_valid <= hold_nx && (blk_valid || !rv_nx);
         s_wready  <= fill_nx;
         busy      <= !(fill_nx && (cnt_nx == '0) && !rv_nx);
      end
   end

endmodule

// File: tb/tb_aes_block_gasket.sv
// Directed bench for aes_block_gasket: key load, FIPS-197 block, backpressure,
// overlap of fill with drain, spurious result and mid-group reset.
module tb_aes_block_gasket;

   logic         ACLK = 1'b0;
   logic         ARESET;
   logic [31:0]  s_wdata;
   logic         s_wkey;
   logic         s_wvalid;
   logic         s_wready;
   logic [127:0] key_out;
   logic         key_valid;
   logic [127:0] blk_out;
   logic         blk_valid;
   logic         blk_ready;
   logic [127:0] res_in;
   logic         res_valid;
   logic [31:0]  m_rdata;
   logic         m_rvalid;
   logic         m_rready;
   logic         busy;
   logic         ovf_err;

   int total = 0;
   int bad   = 0;

   aes_block_gasket dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .s_wdata(s_wdata), .s_wkey(s_wkey), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .key_out(key_out), .key_valid(key_valid),
      .blk_out(blk_out), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .res_in(res_in), .res_valid(res_valid),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
      .busy(busy), .ovf_err(ovf_err)
   );

   always #5 ACLK = ~ACLK;

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Writes one 4-word group, word 0 first, keeping valid high across words
   task automatic put_group(input logic [127:0] g, input logic k);
      int n;
      for (int i = 0; i < 4; i++) begin
         n = 0;
         while (!s_wready && n < 100) begin
            s_wvalid = 1'b0;
            step();
            n++;
         end
         if (!s_wready) begin
            total++; bad++;
            $display("FAIL put_group ready timeout word=%0d", i);
         end
         s_wdata  = g[127 - 32*i -: 32];
         s_wkey   = (i == 0) ? k : 1'b1 - k;
         s_wvalid = 1'b1;
         step();
      end
      s_wvalid = 1'b0;
      s_wkey   = 1'b0;
   endtask

   // Stub AES core: optional stall, handshake, result three cycles later
   task automatic core_round(input logic [127:0] res, input int stall);
      int n;
      logic [127:0] saved;
      n = 0;
      while (!blk_valid && n < 200) begin
         step();
         n++;
      end
      total++;
      if (!blk_valid) begin
         bad++;
         $display("FAIL core_wait blk_valid timeout");
      end
      saved = blk_out;
      for (int s = 0; s < stall; s++) begin
         blk_ready = 1'b0;
         step();
         total++;
         if (blk_valid !== 1'b1 || blk_out !== saved || s_wready !== 1'b0) begin
            bad++;
            $display("FAIL core_stall cyc=%0d got v=%b rdy=%b blk=%h want v=1 rdy=0 blk=%h",
                     s, blk_valid, s_wready, blk_out, saved);
         end
      end
      blk_ready = 1'b1;
      step();
      blk_ready = 1'b0;
      total++;
      if (blk_valid !== 1'b0) begin
         bad++;
         $display("FAIL core_accept blk_valid got %b want 0", blk_valid);
      end
      step();
      res_in    = res;
      res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      res_in    = '0;
      total++;
      if (m_rvalid !== 1'b1 || m_rdata !== res[127:96] || s_wready !== 1'b1) begin
         bad++;
         $display("FAIL core_result got v=%b d=%h wr=%b want v=1 d=%h wr=1",
                  m_rvalid, m_rdata, s_wready, res[127:96]);
      end
   endtask

   // Drains 4 words; toggle=1 alternates m_rready to exercise stalls
   task automatic drain(input logic [127:0] exp, input logic toggle);
      int idx;
      int cyc;
      logic [31:0] pd;
      logic pv;
      logic pr;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 100) begin
         pd = m_rdata;
         pv = m_rvalid;
         pr = toggle ? (cyc % 2 == 0) : 1'b1;
         m_rready = pr;
         step();
         if (pv && pr) begin
            total++;
            if (pd !== exp[127 - 32*idx -: 32]) begin
               bad++;
               $display("FAIL drain word=%0d got %h want %h", idx, pd, exp[127 - 32*idx -: 32]);
            end
            idx++;
         end else if (pv) begin
            total++;
            if (m_rvalid !== 1'b1 || m_rdata !== pd) begin
               bad++;
               $display("FAIL drain_stall word=%0d got v=%b d=%h want v=1 d=%h",
                        idx, m_rvalid, m_rdata, pd);
            end
         end
         cyc++;
      end
      m_rready = 1'b0;
      total++;
      if (idx != 4 || m_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL drain_end got words=%0d v=%b want words=4 v=0", idx, m_rvalid);
      end
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      step();
      step();
      ARESET = 1'b0;
      total++;
      if (key_out !== '0 || blk_out !== '0 || key_valid !== 1'b0 || blk_valid !== 1'b0 ||
          m_rvalid !== 1'b0 || m_rdata !== '0 || ovf_err !== 1'b0 || busy !== 1'b0 ||
          s_wready !== 1'b1) begin
         bad++;
         $display("FAIL reset got key=%h blk=%h kv=%b bv=%b rv=%b rd=%h ovf=%b busy=%b wr=%b want zeros wr=1",
                  key_out, blk_out, key_valid, blk_valid, m_rvalid, m_rdata, ovf_err, busy, s_wready);
      end
   endtask

   task automatic test_key();
      put_group(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
      total++;
      if (key_valid !== 1'b1 || key_out !== 128'h000102030405060708090a0b0c0d0e0f) begin
         bad++;
         $display("FAIL key_load got kv=%b key=%h want kv=1 key=000102030405060708090a0b0c0d0e0f",
                  key_valid, key_out);
      end
      step();
      total++;
      if (key_valid !== 1'b0 || blk_valid !== 1'b0 || s_wready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL key_after got kv=%b bv=%b wr=%b busy=%b want 0 0 1 0",
                  key_valid, blk_valid, s_wready, busy);
      end
      step();
      total++;
      if (blk_valid !== 1'b0) begin
         bad++;
         $display("FAIL key_noblk got bv=%b want 0", blk_valid);
      end
   endtask

   task automatic test_fips();
      put_group(128'h00112233445566778899aabbccddeeff, 1'b0);
      total++;
      if (blk_valid !== 1'b1 || blk_out !== 128'h00112233445566778899aabbccddeeff ||
          s_wready !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL fips_blk got v=%b blk=%h wr=%b busy=%b want v=1 blk=00112233445566778899aabbccddeeff wr=0 busy=1",
                  blk_valid, blk_out, s_wready, busy);
      end
      core_round(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
      drain(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL fips_idle busy got %b want 0", busy);
      end
   endtask

   task automatic test_backpressure();
      put_group(128'hdeadbeef0123456789abcdeffedcba98, 1'b0);
      core_round(128'h1111111122222222333333334444444f, 5);
      drain(128'h1111111122222222333333334444444f, 1'b1);
   endtask

   task automatic test_overlap();
      put_group(128'ha0a0a0a0b1b1b1b1c2c2c2c2d3d3d3d3, 1'b0);
      core_round(128'h0102030411121314212223243132333f, 0);
      m_rready = 1'b0;
      put_group(128'hcafef00d5555aaaa12344321feedface, 1'b0);
      step();
      step();
      total++;
      if (blk_valid !== 1'b0 || blk_out !== 128'hcafef00d5555aaaa12344321feedface || m_rvalid !== 1'b1) begin
         bad++;
         $display("FAIL overlap_gate got bv=%b blk=%h rv=%b want bv=0 blk=cafef00d5555aaaa12344321feedface rv=1",
                  blk_valid, blk_out, m_rvalid);
      end
      drain(128'h0102030411121314212223243132333f, 1'b0);
      total++;
      if (blk_valid !== 1'b1) begin
         bad++;
         $display("FAIL overlap_release blk_valid got %b want 1", blk_valid);
      end
      core_round(128'hfedcba9876543210f0e1d2c3b4a59687, 0);
      drain(128'hfedcba9876543210f0e1d2c3b4a59687, 1'b0);
   endtask

   task automatic test_spurious();
      res_in    = 128'h99999999888888887777777766666666;
      res_valid = 1'b1;
      step();
      res_valid = 1'b0;
      res_in    = '0;
      step();
      total++;
      if (ovf_err !== 1'b1 || m_rvalid !== 1'b0 || s_wready !== 1'b1) begin
         bad++;
         $display("FAIL spurious got ovf=%b rv=%b wr=%b want 1 0 1", ovf_err, m_rvalid, s_wready);
      end
      put_group(128'h0f0e0d0c0b0a09080706050403020100, 1'b0);
      core_round(128'h13579bdf2468ace0aaaabbbbccccdddd, 0);
      drain(128'h13579bdf2468ace0aaaabbbbccccdddd, 1'b0);
      total++;
      if (ovf_err !== 1'b1) begin
         bad++;
         $display("FAIL ovf_sticky got %b want 1", ovf_err);
      end
   endtask

   task automatic test_midreset();
      s_wdata  = 32'h77777777;
      s_wkey   = 1'b0;
      s_wvalid = 1'b1;
      step();
      s_wdata  = 32'h88888888;
      step();
      s_wvalid = 1'b0;
      ARESET   = 1'b1;
      step();
      ARESET   = 1'b0;
      total++;
      if (key_out !== '0 || blk_out !== '0 || blk_valid !== 1'b0 || m_rvalid !== 1'b0 ||
          ovf_err !== 1'b0 || busy !== 1'b0 || s_wready !== 1'b1 || key_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset got key=%h blk=%h bv=%b rv=%b ovf=%b busy=%b wr=%b want zeros wr=1",
                  key_out, blk_out, blk_valid, m_rvalid, ovf_err, busy, s_wready);
      end
      put_group(128'h10203040506070808070605040302010, 1'b0);
      total++;
      if (blk_valid !== 1'b1 || blk_out !== 128'h10203040506070808070605040302010) begin
         bad++;
         $display("FAIL midreset_group got v=%b blk=%h want v=1 blk=10203040506070808070605040302010",
                  blk_valid, blk_out);
      end
      core_round(128'h0badc0de0badc0de0badc0de0badc0de, 0);
      drain(128'h0badc0de0badc0de0badc0de0badc0de, 1'b0);
   endtask

   initial begin
      ARESET    = 1'b1;
      s_wdata   = '0;
      s_wkey    = 1'b0;
      s_wvalid  = 1'b0;
      blk_ready = 1'b0;
      res_in    = '0;
      res_valid = 1'b0;
      m_rready  = 1'b0;
      test_reset();
      test_key();
      test_fips();
      test_backpressure();
      test_overlap();
      test_spurious();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
